fft_psd_avg: RTL and testbench

- Downstream consumer of the FFT output stream (bit-dereversed, natural bin order, `o_new_fft` marks bin 0).
- Computes per-bin power I²+Q² and averages it over 2^AVG_LOG2 consecutive FFT frames in an internal RAM.
- Emits one averaged power spectrum, in bin order, every 2^AVG_LOG2 input frames.
- Feeds spectrum display and detection logic.

---
 rtl/fft_psd_avg_if.sv | 36 +++
 rtl/fft_psd_avg.sv | 205 ++++++++++++++++++++
 tb/tb_fft_psd_avg.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_psd_avg_if.sv
// Stream interface between the FFT output and the PSD averager.
// Carries input I/Q samples with frame marker, averaged power output and optional peak report.
// No backpressure: the producer streams with i_vld only, the averager never stalls.
interface fft_psd_avg_if #(
  parameter int IN_W    = 20,
  parameter int FFT_LEN = 256
);
  localparam int STAGES = $clog2(FFT_LEN);
  localparam int PWR_W  = 2 * IN_W;

  logic                     i_init;
  logic                     i_vld;
  logic                     i_new_fft;
  logic signed [IN_W-1:0]   i_I;
  logic signed [IN_W-1:0]   i_Q;
  logic                     o_vld;
  logic                     o_new_frame;
  logic        [STAGES-1:0] o_bin;
  logic        [PWR_W-1:0]  o_pwr;
  logic                     o_sync_err;
  logic                     o_peak_vld;
  logic        [STAGES-1:0] o_peak_bin;
  logic        [PWR_W-1:0]  o_peak_pwr;

  modport master (
    output i_init, i_vld, i_new_fft, i_I, i_Q,
    input  o_vld, o_new_frame, o_bin, o_pwr, o_sync_err,
    input  o_peak_vld, o_peak_bin, o_peak_pwr
  );

  modport slave (
    input  i_init, i_vld, i_new_fft, i_I, i_Q,
    output o_vld, o_new_frame, o_bin, o_pwr, o_sync_err,
    output o_peak_vld, o_peak_bin, o_peak_pwr
  );
endinterface

// File: rtl/fft_psd_avg.sv
// Per-bin power I^2+Q^2 averaged over 2^AVG_LOG2 FFT frames, one spectrum out per block.
// Latency: o_vld exactly 3 cycles after each accepted sample of the last frame.
// Backpressure: none; input gaps (i_vld=0) are tolerated, output is never stalled.
// Ports: mclk, i_rst_n (async active-low), bus (slave modport: i_init/i_vld/i_new_fft/i_I/i_Q
//   in; o_vld/o_new_frame/o_bin/o_pwr/o_sync_err/o_peak_* out).
// Optional peak tracker enabled by defining PSD_AVG_PEAK_EN; otherwise o_peak_* are tied to 0.
module fft_psd_avg #(
  parameter int IN_W     = 20,
  parameter int FFT_LEN  = 256,
  parameter int AVG_LOG2 = 4
) (
  input  logic          mclk,
  input  logic          i_rst_n,
  fft_psd_avg_if.slave  bus
);
  localparam int STAGES   = $clog2(FFT_LEN);
  localparam int PWR_W    = 2 * IN_W;
  localparam int ACC_W    = PWR_W + AVG_LOG2;
  localparam int LAST_BIN = FFT_LEN - 1;
  localparam int LAST_FRM = (1 << AVG_LOG2) - 1;
  localparam int HALF     = 1 << (AVG_LOG2 - 1);

  typedef enum logic {WAIT_SYNC, ACCUM} state_t;

  state_t              state;
  logic [STAGES-1:0]   bin_cnt;
  logic [AVG_LOG2-1:0] frm_cnt;

  // Input decode: which sample is accepted, with which bin/frame tag, and framing errors.
  logic                acc;
  logic                err;
  logic [STAGES-1:0]   s_bin;
  logic [AVG_LOG2-1:0] s_frm;

  always_comb begin
    acc   = 1'b0;
    err   = 1'b0;
    s_bin = bin_cnt;
    s_frm = frm_cnt;
    if (bus.i_vld) begin
      if (state == WAIT_SYNC) begin
        if (bus.i_new_fft) begin
          acc   = 1'b1;
          s_bin = '0;
          s_frm = '0;
        end
      end else if (bus.i_new_fft) begin
        acc = 1'b1;
        // Marker mid-frame: restart the average from this sample.
        if (bin_cnt != '0) begin
          err   = 1'b1;
          s_bin = '0;
          s_frm = '0;
        end
      end else if (bin_cnt == '0) begin
        err = 1'b1;             // frame start without marker: drop and resync
      end else begin
        acc = 1'b1;
      end
    end
  end

  // Pipeline data path (no reset needed; qualified by the valid bits below).
  logic signed [PWR_W-1:0] i_x, q_x;
  assign i_x = $signed({{IN_W{bus.i_I[IN_W-1]}}, bus.i_I});
  assign q_x = $signed({{IN_W{bus.i_Q[IN_W-1]}}, bus.i_Q});

  logic [ACC_W-1:0]  ram [FFT_LEN];
  logic [PWR_W-1:0]  ii1, qq1, pwr2;
  logic [ACC_W-1:0]  rd1, rd2;
  logic [STAGES-1:0] bin1, bin2;
  logic              first1, first2, last1, last2;
  logic              v1, v2;

  logic [ACC_W-1:0]  sum, rnd;
  logic [PWR_W-1:0]  res;
  logic              out_fire;

  assign sum      = (first2 ? '0 : rd2) + {{AVG_LOG2{1'b0}}, pwr2};
  assign rnd      = sum + ACC_W'(HALF);
  assign res      = rnd[ACC_W-1:AVG_LOG2];
  assign out_fire = v2 & last2;

  always_ff @(posedge mclk) begin
    ii1    <= i_x * i_x;
    qq1    <= q_x * q_x;
    rd1    <= ram[s_bin];
    bin1   <= s_bin;
    first1 <= (s_frm == '0);
    last1  <= (s_frm == AVG_LOG2'(LAST_FRM));
    pwr2   <= ii1 + qq1;
    rd2    <= rd1;
    bin2   <= bin1;
    first2 <= first1;
    last2  <= last1;
    if (v2) ram[bin2] <= sum;
  end

  // Control FSM, pipeline valids and registered outputs.
  logic              vld_q, new_frame_q, sync_err_q;
  logic [STAGES-1:0] bin_q;
  logic [PWR_W-1:0]  pwr_q;

  always_ff @(posedge mclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= WAIT_SYNC;
      bin_cnt     <= '0;
      frm_cnt     <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      vld_q       <= 1'b0;
      new_frame_q <= 1'b0;
      sync_err_q  <= 1'b0;
      bin_q       <= '0;
      pwr_q       <= '0;
    end else if (bus.i_init) begin
      state       <= WAIT_SYNC;
      bin_cnt     <= '0;
      frm_cnt     <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      vld_q       <= 1'b0;
      new_frame_q <= 1'b0;
      sync_err_q  <= 1'b0;
      bin_q       <= '0;
      pwr_q       <= '0;
    end else begin
      sync_err_q <= err;
      if (acc) begin
        state <= ACCUM;
        if (s_bin == STAGES'(LAST_BIN)) begin
          bin_cnt <= '0;
          frm_cnt <= s_frm + 1'b1;   // wraps naturally at 2^AVG_LOG2
        end else begin
          bin_cnt <= s_bin + 1'b1;
          frm_cnt <= s_frm;
        end
      end else if (err) begin
        state <= WAIT_SYNC;
      end
      v1          <= acc;
      v2          <= v1;
      vld_q       <= out_fire;
      new_frame_q <= out_fire && (bin2 == '0);
      if (out_fire) begin
        bin_q <= bin2;
        pwr_q <= res;
      end
    end
  end

  assign bus.o_vld       = vld_q;
  assign bus.o_new_frame = new_frame_q;
  assign bus.o_bin       = bin_q;
  assign bus.o_pwr       = pwr_q;
  assign bus.o_sync_err  = sync_err_q;

`ifdef PSD_AVG_PEAK_EN
  // Peak tracker over each output frame; strict '>' keeps the lowest bin on ties.
  logic              pk_act, pk_done, pk_vld_q;
  logic [STAGES-1:0] pk_bin, pk_bin_q;
  logic [PWR_W-1:0]  pk_pwr, pk_pwr_q;

  always_ff @(posedge mclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pk_act <= 1'b0; pk_done <= 1'b0; pk_vld_q <= 1'b0;
      pk_bin <= '0;   pk_pwr  <= '0;   pk_bin_q <= '0; pk_pwr_q <= '0;
    end else if (bus.i_init) begin
      pk_act <= 1'b0; pk_done <= 1'b0; pk_vld_q <= 1'b0;
      pk_bin <= '0;   pk_pwr  <= '0;   pk_bin_q <= '0; pk_pwr_q <= '0;
    end else begin
      pk_done  <= 1'b0;
      pk_vld_q <= pk_done;
      if (pk_done) begin
        pk_bin_q <= pk_bin;
        pk_pwr_q <= pk_pwr;
      end
      if (out_fire) begin
        if (bin2 == '0) begin
          pk_act <= 1'b1;
          pk_bin <= '0;
          pk_pwr <= res;
        end else if (pk_act && (res > pk_pwr)) begin
          pk_bin <= bin2;
          pk_pwr <= res;
        end
        if (pk_act && (bin2 == STAGES'(LAST_BIN))) pk_done <= 1'b1;
      end
      // A framing error abandons whatever peak is being collected.
      if (err) begin
        pk_act  <= 1'b0;
        pk_done <= 1'b0;
      end
    end
  end

  assign bus.o_peak_vld = pk_vld_q;
  assign bus.o_peak_bin = pk_bin_q;
  assign bus.o_peak_pwr = pk_pwr_q;
`else
  assign bus.o_peak_vld = 1'b0;
  assign bus.o_peak_bin = '0;
  assign bus.o_peak_pwr = '0;
`endif
endmodule

// File: tb/tb_fft_psd_avg.sv
// Scoreboard bench for fft_psd_avg: stimulus pushes hand-computed expectations into queues,
// a negedge monitor pops and compares whenever the DUT presents o_vld / o_sync_err / o_peak_vld.
module tb_fft_psd_avg;
  localparam int IN_W     = 8;
  localparam int FFT_LEN  = 8;
  localparam int AVG_LOG2 = 2;

  logic mclk = 1'b0;
  logic rst_n;
  always #5 mclk = ~mclk;

  fft_psd_avg_if #(.IN_W(IN_W), .FFT_LEN(FFT_LEN)) bus ();

  fft_psd_avg #(.IN_W(IN_W), .FFT_LEN(FFT_LEN), .AVG_LOG2(AVG_LOG2)) dut (
    .mclk    (mclk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {int cyc; int bin; int pwr;} exp_t;
  exp_t oq[$];
  exp_t pq[$];
  int   eq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge mclk) cyc++;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor
  always @(negedge mclk) begin
    exp_t e;
    if (bus.o_vld) begin
      if (oq.size() == 0) chk("o_vld_unexpected", bus.o_vld, 0);
      else begin
        e = oq.pop_front();
        chk("o_vld_cycle", cyc, e.cyc);
        chk("o_bin", bus.o_bin, e.bin);
        chk("o_pwr", bus.o_pwr, e.pwr);
        chk("o_new_frame", bus.o_new_frame, (e.bin == 0) ? 1 : 0);
`ifndef PSD_AVG_PEAK_EN
        chk("peak_ports_zero", {bus.o_peak_vld, bus.o_peak_bin, bus.o_peak_pwr}, 0);
`endif
      end
    end else if (oq.size() > 0 && oq[0].cyc < cyc) begin
      e = oq.pop_front();
      chk("o_vld_missing", bus.o_vld, 1);
    end

    if (bus.o_sync_err) begin
      if (eq.size() == 0) chk("o_sync_err_unexpected", bus.o_sync_err, 0);
      else chk("o_sync_err_cycle", cyc, eq.pop_front());
    end else if (eq.size() > 0 && eq[0] < cyc) begin
      void'(eq.pop_front());
      chk("o_sync_err_missing", bus.o_sync_err, 1);
    end

`ifdef PSD_AVG_PEAK_EN
    if (bus.o_peak_vld) begin
      if (pq.size() == 0) chk("o_peak_vld_unexpected", bus.o_peak_vld, 0);
      else begin
        e = pq.pop_front();
        chk("o_peak_cycle", cyc, e.cyc);
        chk("o_peak_bin", bus.o_peak_bin, e.bin);
        chk("o_peak_pwr", bus.o_peak_pwr, e.pwr);
      end
    end else if (pq.size() > 0 && pq[0].cyc < cyc) begin
      void'(pq.pop_front());
      chk("o_peak_vld_missing", bus.o_peak_vld, 1);
    end
`endif
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge mclk);
      bus.i_vld     = 1'b0;
      bus.i_new_fft = 1'b0;
    end
  endtask

  // One input sample; eo/ebin/epwr describe the averaged output it must produce.
  task automatic sample(input bit nf, input int iv, input int qv, input bit eo,
                        input int ebin, input int epwr, input bit eerr, input int gap);
    idle(gap);
    @(negedge mclk);
    bus.i_vld     = 1'b1;
    bus.i_new_fft = nf;
    bus.i_I       = IN_W'(iv);
    bus.i_Q       = IN_W'(qv);
    if (eo)   oq.push_back('{cyc + 3, ebin, epwr});
    if (eerr) eq.push_back(cyc + 1);
  endtask

  task automatic push_peak(input int pb, input int pp);
`ifdef PSD_AVG_PEAK_EN
    pq.push_back('{cyc + 4, pb, pp});
`else
    if (pb < 0 || pp < 0) $display("bad peak args");
`endif
  endtask

  // nfr full frames; bin sp_bin uses sp_i. Outputs expected on the last frame only.
  task automatic frames(input int nfr, input int iv, input int qv, input int sp_bin,
                        input int sp_i, input int ep, input int ep_sp, input bit rgap);
    int pb, pp;
    if (sp_bin >= 0 && ep_sp > ep) begin pb = sp_bin; pp = ep_sp; end
    else if (sp_bin == 0 && ep_sp < ep) begin pb = 1; pp = ep; end
    else begin pb = 0; pp = ep; end
    for (int f = 0; f < nfr; f++) begin
      for (int b = 0; b < FFT_LEN; b++) begin
        sample(b == 0, (b == sp_bin) ? sp_i : iv, qv, f == nfr - 1, b,
               (b == sp_bin) ? ep_sp : ep, 1'b0, rgap ? int'($urandom_range(0, 1)) : 0);
        if (f == nfr - 1 && b == FFT_LEN - 1) push_peak(pb, pp);
      end
    end
  endtask

  initial begin
    logic [3:0] pats [3];
    int         exps [3];
    pats = '{4'b0111, 4'b0001, 4'b0011};
    exps = '{1, 0, 1};

    bus.i_init = 1'b0; bus.i_vld = 1'b0; bus.i_new_fft = 1'b0;
    bus.i_I = '0; bus.i_Q = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    chk("reset_o_vld", bus.o_vld, 0);
    chk("reset_o_pwr", bus.o_pwr, 0);
    chk("reset_o_bin", bus.o_bin, 0);
    chk("reset_o_sync_err", bus.o_sync_err, 0);
    chk("reset_o_peak", {bus.o_peak_vld, bus.o_peak_bin, bus.o_peak_pwr}, 0);
    @(negedge mclk); rst_n = 1'b1;
    idle(2);

    // 1: constant 3+4j -> 25, then a frame start without marker
    frames(4, 3, 4, -1, 0, 25, 0, 1'b0);
    idle(6);
    sample(1'b0, 3, 4, 1'b0, 0, 0, 1'b1, 0);
    sample(1'b0, 3, 4, 1'b0, 0, 0, 1'b0, 0);   // discarded while resyncing
    idle(4);

    // 2: rounding on bin 0
    for (int p = 0; p < 3; p++) begin
      for (int f = 0; f < 4; f++)
        for (int b = 0; b < FFT_LEN; b++) begin
          sample(b == 0, (b == 0 && pats[p][f]) ? 1 : 0, 0, f == 3, b,
                 (b == 0) ? exps[p] : 0, 1'b0, 0);
          if (f == 3 && b == FFT_LEN - 1) push_peak(0, exps[p]);
        end
    end

    // 3: full-scale negative, back-to-back then with random gaps
    frames(4, -128, -128, -1, 0, 32768, 0, 1'b0);
    frames(4, -128, -128, -1, 0, 32768, 0, 1'b1);

    // 4: marker at bin 5 mid-frame restarts the average
    for (int b = 0; b < 13; b++) sample((b % 8) == 0, 3, 0, 1'b0, 0, 0, 1'b0, 0);
    sample(1'b1, 2, 0, 1'b0, 0, 0, 1'b1, 0);
    for (int b = 1; b < FFT_LEN; b++) sample(1'b0, 2, 0, 1'b0, 0, 0, 1'b0, 0);
    frames(3, 2, 0, -1, 0, 4, 0, 1'b0);
    idle(6);

    // 5a: async reset in frame 2
    for (int b = 0; b < 11; b++) sample((b % 8) == 0, 1, 1, 1'b0, 0, 0, 1'b0, 0);
    @(negedge mclk); bus.i_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_o_pwr", bus.o_pwr, 0);
    chk("async_rst_o_bin", bus.o_bin, 0);
    chk("async_rst_o_vld", bus.o_vld, 0);
    @(negedge mclk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) sample(1'b0, 5, 5, 1'b0, 0, 0, 1'b0, 0);
    frames(4, 1, 1, -1, 0, 2, 0, 1'b0);
    idle(6);

    // 5b: synchronous init in frame 2
    for (int b = 0; b < 11; b++) sample((b % 8) == 0, 3, 3, 1'b0, 0, 0, 1'b0, 0);
    @(negedge mclk); bus.i_vld = 1'b0; bus.i_init = 1'b1;
    @(negedge mclk); bus.i_init = 1'b0;
    chk("init_o_pwr", bus.o_pwr, 0);
    chk("init_o_bin", bus.o_bin, 0);
    for (int k = 0; k < 3; k++) sample(1'b0, 5, 5, 1'b0, 0, 0, 1'b0, 0);
    frames(4, 2, 2, -1, 0, 8, 0, 1'b0);

    // 6: peak at bin 6
    frames(4, 3, 0, 6, 10, 9, 100, 1'b0);
    idle(12);

    chk("pending_outputs", oq.size(), 0);
    chk("pending_sync_err", eq.size(), 0);
    chk("pending_peaks", pq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
